game_ctl: RTL and testbench

- Top-level Pong game sequencer. Sits between the debouncers/ball_ctl and the drawing chain.
- Tracks game phase, score, lives and ball speed, and gates/re-serves the ball datapath (ball_ctl) via enable/load strobes.
- Frame-paced timing is derived from the VGA vsync, so all delays are counted in frames.

---
 rtl/game_ctl.sv | 184 ++++++++++++++++++
 tb/tb_game_ctl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctl.sv
// Pong game sequencer: phase, score, lives and speed control for the ball datapath.
// All timing is counted in frames (rising edges of vsync).
//
// state   | meaning
// S_IDLE  | power-up attract screen, waiting for start
// S_SERVE | ball re-centred, counting down to release
// S_PLAY  | ball in motion, scoring hits, watching for a miss
// S_MISS  | ball frozen after a miss
// S_OVER  | no lives left, waiting for start
module game_ctl #(
  parameter int SERVE_FRAMES     = 60,
  parameter int MISS_FRAMES      = 30,
  parameter int LIVES            = 3,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int MAX_SPEED        = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       btn_start,
  input  logic       paddle_hit,
  input  logic       ball_miss,
  input  logic [3:0] random_4,
  output logic       ball_en,
  output logic       ball_load,
  output logic [3:0] serve_angle,
  output logic [2:0] ball_speed,
  output logic [7:0] score,
  output logic [2:0] lives,
  output logic       game_over,
  output logic       blink
);

  localparam int FMAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);
  localparam int HW   = $clog2(HITS_PER_SPEEDUP + 1);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_MISS, S_OVER} state_t;

  state_t         state, state_nxt;
  logic           vsync_q, btn_q;
  logic           frame_tick, start_evt, new_game;
  logic [FW-1:0]  frame_cnt, frame_cnt_nxt;
  logic [HW-1:0]  hit_cnt, hit_cnt_nxt;
  logic [3:0]     blink_cnt, blink_cnt_nxt;
  logic           ball_en_nxt, ball_load_nxt, game_over_nxt, blink_nxt;
  logic [3:0]     serve_angle_nxt;
  logic [2:0]     ball_speed_nxt, lives_nxt;
  logic [7:0]     score_nxt;

  assign frame_tick = vsync & ~vsync_q;
  assign start_evt  = btn_start & ~btn_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      vsync_q     <= 1'b0;
      btn_q       <= 1'b0;
      frame_cnt   <= '0;
      hit_cnt     <= '0;
      blink_cnt   <= '0;
      ball_en     <= 1'b0;
      ball_load   <= 1'b0;
      serve_angle <= '0;
      ball_speed  <= 3'd1;
      score       <= '0;
      lives       <= 3'(LIVES);
      game_over   <= 1'b0;
      blink       <= 1'b0;
    end else begin
      state       <= state_nxt;
      vsync_q     <= vsync;
      btn_q       <= btn_start;
      frame_cnt   <= frame_cnt_nxt;
      hit_cnt     <= hit_cnt_nxt;
      blink_cnt   <= blink_cnt_nxt;
      ball_en     <= ball_en_nxt;
      ball_load   <= ball_load_nxt;
      serve_angle <= serve_angle_nxt;
      ball_speed  <= ball_speed_nxt;
      score       <= score_nxt;
      lives       <= lives_nxt;
      game_over   <= game_over_nxt;
      blink       <= blink_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    new_game        = 1'b0;
    frame_cnt_nxt   = frame_cnt;
    hit_cnt_nxt     = hit_cnt;
    blink_cnt_nxt   = blink_cnt;
    ball_en_nxt     = ball_en;
    ball_load_nxt   = 1'b0;
    serve_angle_nxt = serve_angle;
    ball_speed_nxt  = ball_speed;
    score_nxt       = score;
    lives_nxt       = lives;
    game_over_nxt   = game_over;
    blink_nxt       = blink;

    case (state)
      S_IDLE, S_OVER: begin
        if (start_evt) begin
          state_nxt     = S_SERVE;
          new_game      = 1'b1;
          game_over_nxt = 1'b0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt == FW'(1)) begin
            state_nxt   = S_PLAY;
            ball_en_nxt = 1'b1;
          end else begin
            frame_cnt_nxt = frame_cnt - FW'(1);
          end
        end
      end
      S_PLAY: begin
        // a miss in the same cycle as a hit wins; the hit is dropped
        if (ball_miss) begin
          state_nxt     = S_MISS;
          lives_nxt     = lives - 3'd1;
          ball_en_nxt   = 1'b0;
          frame_cnt_nxt = FW'(MISS_FRAMES);
        end else if (paddle_hit) begin
          if (score != 8'h99) begin
            if (score[3:0] == 4'd9) score_nxt = {score[7:4] + 4'd1, 4'd0};
            else                    score_nxt = {score[7:4], score[3:0] + 4'd1};
          end
          if (hit_cnt == HW'(HITS_PER_SPEEDUP - 1)) begin
            hit_cnt_nxt = '0;
            if (ball_speed < 3'(MAX_SPEED)) ball_speed_nxt = ball_speed + 3'd1;
          end else begin
            hit_cnt_nxt = hit_cnt + HW'(1);
          end
        end
      end
      S_MISS: begin
        if (frame_tick) begin
          if (frame_cnt == FW'(1)) begin
            if (lives == 3'd0) begin
              state_nxt     = S_OVER;
              game_over_nxt = 1'b1;
            end else begin
              state_nxt = S_SERVE;
            end
          end else begin
            frame_cnt_nxt = frame_cnt - FW'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (new_game) begin
      score_nxt      = '0;
      lives_nxt      = 3'(LIVES);
      ball_speed_nxt = 3'd1;
      hit_cnt_nxt    = '0;
    end

    if (state_nxt == S_SERVE && state != S_SERVE) begin
      ball_load_nxt   = 1'b1;
      serve_angle_nxt = random_4;
      ball_en_nxt     = 1'b0;
      frame_cnt_nxt   = FW'(SERVE_FRAMES);
    end

    // blink only free-runs while parked in an attract state
    if ((state == S_IDLE || state == S_OVER) && state_nxt == state) begin
      if (frame_tick) begin
        blink_cnt_nxt = blink_cnt + 4'd1;
        if (blink_cnt == 4'hf) blink_nxt = ~blink;
      end
    end else begin
      blink_cnt_nxt = '0;
      blink_nxt     = 1'b0;
    end
  end

endmodule

// File: tb/tb_game_ctl.sv
// Randomized bench for game_ctl: a frame-level game model predicts every output change,
// a negedge monitor pops and compares whenever the DUT outputs move.
module tb_game_ctl;

  localparam int SERVE_F = 60;
  localparam int MISS_F  = 30;
  localparam int LIVES_P = 3;
  localparam int HPS     = 4;
  localparam int MAXS    = 7;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_MISS  = 3;
  localparam int PH_OVER  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync, btn_start, paddle_hit, ball_miss;
  logic [3:0] random_4;
  logic       ball_en, ball_load, game_over, blink;
  logic [3:0] serve_angle;
  logic [2:0] ball_speed, lives;
  logic [7:0] score;

  game_ctl #(
    .SERVE_FRAMES(SERVE_F), .MISS_FRAMES(MISS_F), .LIVES(LIVES_P),
    .HITS_PER_SPEEDUP(HPS), .MAX_SPEED(MAXS)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .btn_start(btn_start),
    .paddle_hit(paddle_hit), .ball_miss(ball_miss), .random_4(random_4),
    .ball_en(ball_en), .ball_load(ball_load), .serve_angle(serve_angle),
    .ball_speed(ball_speed), .score(score), .lives(lives),
    .game_over(game_over), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [21:0] vec;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_cnt = 0;
  logic        mon_en = 1'b0;
  logic [21:0] mon_prev, mon_cur;
  exp_t        mon_e;
  logic [21:0] dut_vec;

  assign dut_vec = {ball_en, ball_load, serve_angle, ball_speed, score, lives, game_over, blink};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // game model state
  int          m_phase, m_score, m_lives, m_speed, m_hits, m_frames, m_bt;
  logic [3:0]  m_angle;
  logic        m_en, m_load, m_go, m_pv, m_pb;
  logic [21:0] m_prev_vec;

  // stimulus state
  logic rst_v, btn_v;
  int   r4_fix = -1;
  int   vs_cnt = 0;
  int   vs_per = 6;

  function automatic logic [21:0] model_vec();
    logic [7:0] bcd;
    logic       bl;
    bcd = 8'((m_score / 10) * 16 + (m_score % 10));
    bl  = (m_phase == PH_IDLE || m_phase == PH_OVER) ? ((m_bt / 16) % 2 == 1) : 1'b0;
    return {m_en, m_load, m_angle, 3'(m_speed), bcd, 3'(m_lives), m_go, bl};
  endfunction

  function automatic void model_reset();
    m_phase = PH_IDLE; m_score = 0; m_lives = LIVES_P; m_speed = 1; m_hits = 0;
    m_frames = 0; m_bt = 0; m_angle = 4'h0; m_en = 0; m_load = 0; m_go = 0;
    m_pv = 0; m_pb = 0;
  endfunction

  function automatic void enter_serve(logic [3:0] r4);
    m_phase = PH_SERVE; m_load = 1; m_angle = r4; m_en = 0; m_frames = 0; m_bt = 0;
  endfunction

  function automatic void model_step(logic v, logic b, logic hit, logic miss, logic [3:0] r4);
    logic tick, start;
    tick  = v && !m_pv;
    start = b && !m_pb;
    m_pv = v;
    m_pb = b;
    m_load = 0;
    case (m_phase)
      PH_IDLE, PH_OVER: begin
        if (start) begin
          m_score = 0; m_lives = LIVES_P; m_speed = 1; m_hits = 0; m_go = 0;
          enter_serve(r4);
        end else if (tick) m_bt++;
      end
      PH_SERVE: if (tick) begin
        m_frames++;
        if (m_frames == SERVE_F) begin m_phase = PH_PLAY; m_en = 1; end
      end
      PH_PLAY: begin
        if (miss) begin
          m_lives--; m_en = 0; m_phase = PH_MISS; m_frames = 0;
        end else if (hit) begin
          if (m_score < 99) m_score++;
          m_hits++;
          if (m_hits == HPS) begin
            m_hits = 0;
            if (m_speed < MAXS) m_speed++;
          end
        end
      end
      PH_MISS: if (tick) begin
        m_frames++;
        if (m_frames == MISS_F) begin
          if (m_lives == 0) begin m_phase = PH_OVER; m_go = 1; m_bt = 0; end
          else enter_serve(r4);
        end
      end
      default: ;
    endcase
  endfunction

  task automatic push_if_changed(input int tag);
    logic [21:0] v;
    v = model_vec();
    if (v !== m_prev_vec) begin
      sb_q.push_back('{tag, v});
      m_prev_vec = v;
    end
  endtask

  task automatic step(input logic hit, input logic miss);
    @(posedge clk); #1;
    vsync = (vs_cnt < 2);
    vs_cnt++;
    if (vs_cnt >= vs_per) begin vs_cnt = 0; vs_per = $urandom_range(4, 9); end
    paddle_hit = hit;
    ball_miss  = miss;
    random_4   = (r4_fix >= 0) ? 4'(r4_fix) : 4'($urandom_range(0, 15));
    btn_start  = btn_v;
    rst        = rst_v;
    if (!rst_v) model_reset();
    else model_step(vsync, btn_start, hit, miss, random_4);
    push_if_changed(edge_cnt + 1);
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
  endtask

  task automatic run_until(input int ph, input int budget);
    int k;
    k = 0;
    while (m_phase != ph && k < budget) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      k++;
    end
    n_cmp++;
    if (m_phase != ph) begin
      n_bad++;
      $display("FAIL phase_timeout: actual phase=%0d required phase=%0d", m_phase, ph);
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ball_en"}, 8'(ball_en), 8'h0);
    check({tag, "_ball_load"}, 8'(ball_load), 8'h0);
    check({tag, "_serve_angle"}, 8'(serve_angle), 8'h0);
    check({tag, "_ball_speed"}, 8'(ball_speed), 8'h1);
    check({tag, "_score"}, score, 8'h00);
    check({tag, "_lives"}, 8'(lives), 8'(LIVES_P));
    check({tag, "_game_over"}, 8'(game_over), 8'h0);
    check({tag, "_blink"}, 8'(blink), 8'h0);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin step(1'b1, 1'b0); step(1'b0, 1'b0); end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = dut_vec;
      if (mon_cur !== mon_prev) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: edge=%0d actual=%h required=no change from %h",
                   edge_cnt, mon_cur, mon_prev);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.cyc != edge_cnt || mon_e.vec !== mon_cur) begin
            n_bad++;
            $display("FAIL out_vec: actual edge=%0d vec=%h required edge=%0d vec=%h",
                     edge_cnt, mon_cur, mon_e.cyc, mon_e.vec);
          end
        end
        mon_prev = mon_cur;
      end
    end
  end

  initial begin
    rst = 1'b1; vsync = 0; btn_start = 0; paddle_hit = 0; ball_miss = 0; random_4 = 4'h0;
    rst_v = 1'b0; btn_v = 1'b0;
    model_reset();
    m_prev_vec = model_vec();
    mon_prev   = m_prev_vec;
    #2 rst = 1'b0;
    #1 check_reset_vals("reset");
    mon_en = 1'b1;
    repeat (3) step(1'b0, 1'b0);

    rst_v = 1'b1;
    rand_steps(150);

    r4_fix = 10; btn_v = 1'b1;
    step(1'b0, 1'b0);
    r4_fix = -1;
    step(1'b0, 1'b0);
    check("start_ball_load", 8'(ball_load), 8'h1);
    check("start_angle", 8'(serve_angle), 8'h0a);
    check("start_ball_en", 8'(ball_en), 8'h0);

    run_until(PH_PLAY, 1500);
    step(1'b0, 1'b0);
    check("play_ball_en", 8'(ball_en), 8'h1);

    hits(12);
    check("score_12", score, 8'h12);
    check("speed_12", 8'(ball_speed), 8'h4);
    hits(25);
    check("score_37", score, 8'h37);
    check("speed_sat", 8'(ball_speed), 8'h7);
    hits(62);
    check("score_99", score, 8'h99);
    hits(2);
    check("score_sat", score, 8'h99);

    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("miss1_ball_en", 8'(ball_en), 8'h0);
    check("miss1_lives", 8'(lives), 8'h2);

    run_until(PH_PLAY, 2000);
    step(1'b0, 1'b0);
    check("reserve_speed", 8'(ball_speed), 8'h7);

    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check("hitmiss_lives", 8'(lives), 8'h1);
    check("hitmiss_score", score, 8'h99);

    run_until(PH_PLAY, 2000);
    step(1'b0, 1'b1);
    run_until(PH_OVER, 1000);
    step(1'b0, 1'b0);
    check("over_flag", 8'(game_over), 8'h1);
    check("over_lives", 8'(lives), 8'h0);

    rand_steps(400);

    btn_v = 1'b0;
    rand_steps(3);
    btn_v = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("restart_load", 8'(ball_load), 8'h1);
    check("restart_score", score, 8'h00);
    check("restart_lives", 8'(lives), 8'h3);
    check("restart_speed", 8'(ball_speed), 8'h1);
    check("restart_over", 8'(game_over), 8'h0);
    btn_v = 1'b0;

    run_until(PH_PLAY, 1500);
    hits(5);

    @(posedge clk); #6;
    rst = 1'b0; rst_v = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    push_if_changed(edge_cnt + 1);

    repeat (3) step(1'b0, 1'b0);
    rst_v = 1'b1;
    rand_steps(200);
    repeat (3) step(1'b0, 1'b0);
    @(negedge clk); #1;

    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_change: actual=no change required edge=%0d vec=%h", mon_e.cyc, mon_e.vec);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
